// File: rtl/sde_solver_q824.sv
// One Euler-Maruyama step of the Heston SDE pair in signed Q8.24.
// sqrt_q824 is a combinational square root that also works on its own;
// sde_solver_q824 computes the next (S, v) combinationally from its
// inputs and registers the result when en is high.

// Combinational Q8.24 square root: floor(sqrt(a * 2^24)), or 0 for a <= 0.
module sqrt_q824 (
    input  logic [31:0] a,
    output logic [31:0] sqrt_out
);
    logic [55:0] radicand;
    logic [31:0] rem;
    logic [31:0] trial;
    logic [27:0] root;

    // Unrolled digit-by-digit root: brings down two radicand bits per result bit.
    always_comb begin
        radicand = {a, 24'd0};
        rem      = 32'd0;
        trial    = 32'd0;
        root     = 28'd0;
        for (int i = 27; i >= 0; i--) begin
            rem   = {rem[29:0], radicand[2*i +: 2]};
            trial = {2'b00, root, 2'b01};
            if (rem >= trial) begin
                rem  = rem - trial;
                root = {root[26:0], 1'b1};
            end else begin
                root = {root[26:0], 1'b0};
            end
        end
        if (a[31] || (a == 32'd0)) begin
            sqrt_out = 32'd0;
        end else begin
            sqrt_out = {4'd0, root};
        end
    end
endmodule

module sde_solver_q824 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] S_in,
    input  logic [31:0] v_in,
    input  logic [31:0] dW1,
    input  logic [31:0] dW2,
    input  logic [31:0] dt,
    input  logic [31:0] r,
    input  logic [31:0] kappa,
    input  logic [31:0] theta,
    input  logic [31:0] sigma,
    output logic [31:0] S_out,
    output logic [31:0] v_out
);
    // Full 64-bit two's complement product, then keep bits [55:24]:
    // an arithmetic shift by 24 (floor) wrapped to 32 bits.
    function automatic logic [31:0] qmul(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
        return p[55:24];
    endfunction

    logic [31:0] sq;
    logic [31:0] a1, b1, a2, b2, vd;
    logic [31:0] s_next, v_next;

    sqrt_q824 u_sqrt (
        .a        (v_in),
        .sqrt_out (sq)
    );

    // Next-state datapath; each product truncates on its own, order is fixed.
    always_comb begin
        a1     = qmul(qmul(r, S_in), dt);
        b1     = qmul(qmul(sq, S_in), dW1);
        vd     = theta - v_in;
        a2     = qmul(qmul(kappa, vd), dt);
        b2     = qmul(qmul(sigma, sq), dW2);
        s_next = S_in + (a1 + b1);
        v_next = v_in + (a2 + b2);
    end

    // State registers: reset wins over en, otherwise hold unless stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            S_out <= 32'd0;
            v_out <= 32'd0;
        end else if (en) begin
            S_out <= s_next;
            v_out <= v_next;
        end
    end
endmodule

// File: tb/tb_sde_solver_q824.sv
// Directed and randomized checks of sde_solver_q824 and a standalone sqrt_q824.
module tb_sde_solver_q824;
    logic        clk = 1'b0;
    logic        rst, en;
    logic [31:0] S_in, v_in, dW1, dW2, dt, r, kappa, theta, sigma;
    logic [31:0] S_out, v_out;
    logic [31:0] sq_a, sq_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sde_solver_q824 dut (
        .clk(clk), .rst(rst), .en(en),
        .S_in(S_in), .v_in(v_in), .dW1(dW1), .dW2(dW2), .dt(dt),
        .r(r), .kappa(kappa), .theta(theta), .sigma(sigma),
        .S_out(S_out), .v_out(v_out)
    );

    sqrt_q824 u_sq (.a(sq_a), .sqrt_out(sq_o));

    function automatic int m_qmul(input int x, input int y);
        longint p;
        p = longint'(x) * longint'(y);
        return int'(p >>> 24);
    endfunction

    // Reference root via real sqrt, then nudged to the exact integer floor.
    function automatic int m_sqrt(input int x);
        longint n, y;
        if (x <= 0) return 0;
        n = longint'(x) <<< 24;
        y = longint'($sqrt(real'(n)));
        while (y * y > n) y--;
        while ((y + 1) * (y + 1) <= n) y++;
        return int'(y);
    endfunction

    function automatic int m_s(input int s, input int v, input int rr, input int t, input int w1);
        int q;
        q = m_sqrt(v);
        return s + (m_qmul(m_qmul(rr, s), t) + m_qmul(m_qmul(q, s), w1));
    endfunction

    function automatic int m_v(input int v, input int k, input int th, input int sg,
                               input int t, input int w2);
        int q;
        q = m_sqrt(v);
        return v + (m_qmul(m_qmul(k, th - v), t) + m_qmul(m_qmul(sg, q), w2));
    endfunction

    function automatic int absdiff(input int x, input int y);
        longint d;
        d = longint'(x) - longint'(y);
        return (d < 0) ? int'(-d) : int'(d);
    endfunction

    task automatic set_inputs(input int s, input int v, input int w1, input int w2, input int t,
                              input int rr, input int k, input int th, input int sg);
        S_in = s; v_in = v; dW1 = w1; dW2 = w2; dt = t;
        r = rr; kappa = k; theta = th; sigma = sg;
    endtask

    task automatic pulse_en();
        @(negedge clk); en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1'b1; en = 1'b0;
        set_inputs(32'h64000000, 671089, 1677722, -1677722, 167772, 838861, 33554432, 1509949, 5033165);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (S_out !== 32'd0 || v_out !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_idle: S_out=%h v_out=%h expected 0/0", S_out, v_out);
        end
        @(negedge clk); en = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (S_out !== 32'd0 || v_out !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_over_en: S_out=%h v_out=%h expected 0/0", S_out, v_out);
        end
        @(negedge clk); en = 1'b0; rst = 1'b0;
    endtask

    logic [31:0] held_s, held_v;

    task automatic test_nominal();
        int es, ev;
        set_inputs(32'h64000000, 671089, 1677722, -1677722, 167772, 838861, 33554432, 1509949, 5033165);
        es = m_s(32'h64000000, 671089, 838861, 167772, 1677722);
        ev = m_v(671089, 33554432, 1509949, 5033165, 167772, -1677722);
        pulse_en();
        vectors++;
        if (absdiff(S_out, 32'h660CCCCD) > 200) begin
            miscompares++;
            $display("FAIL nominal_s_hand: S_out=%h expected ~660ccccd", S_out);
        end
        vectors++;
        if (absdiff(v_out, 587203) > 200) begin
            miscompares++;
            $display("FAIL nominal_v_hand: v_out=%0d expected ~587203", v_out);
        end
        vectors++;
        if (absdiff(S_out, es) > 200 || absdiff(v_out, ev) > 200) begin
            miscompares++;
            $display("FAIL nominal_model: S_out=%h v_out=%h expected %h %h", S_out, v_out, es, ev);
        end
        held_s = S_out;
        held_v = v_out;
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_inputs(32'h10000000 + i * 4096, 3000000 + i, 100000, 200000, 50000,
                       -100000, 20000000, 4000000, 9000000);
            @(posedge clk); #1;
            vectors++;
            if (S_out !== held_s || v_out !== held_v) begin
                miscompares++;
                $display("FAIL hold_%0d: S_out=%h v_out=%h expected %h %h",
                         i, S_out, v_out, held_s, held_v);
            end
        end
    endtask

    task automatic test_sqrt();
        int av[5];
        int ex[5];
        av = '{32'h04000000, 32'h02000000, 32'h01000000, 0, -32'sh01000000};
        ex = '{32'h02000000, 23726566, 32'h01000000, 0, 0};
        for (int i = 0; i < 5; i++) begin
            sq_a = av[i];
            #1;
            vectors++;
            if (sq_o !== ex[i]) begin
                miscompares++;
                $display("FAIL sqrt_%0d: a=%h got %0d expected %0d", i, av[i], sq_o, ex[i]);
            end
        end
    endtask

    task automatic test_zero_variance();
        set_inputs(32'h05000000, 0, 4194304, -4194304, 167772, 0, 32'h01000000, 32'h00800000, 5033165);
        pulse_en();
        vectors++;
        if (S_out !== 32'h05000000) begin
            miscompares++;
            $display("FAIL zero_var_s: S_out=%h expected 05000000", S_out);
        end
        vectors++;
        if (v_out !== 32'd83886) begin
            miscompares++;
            $display("FAIL zero_var_v: v_out=%0d expected 83886", v_out);
        end
    endtask

    task automatic test_random();
        int s, v, w1, w2, t, rr, k, th, sg, es, ev;
        for (int i = 0; i < 10; i++) begin
            s  = int'($urandom_range(1694498816, 16777216));
            v  = int'($urandom_range(169450701, 1677722));
            t  = int'($urandom_range(167772, 33554));
            w1 = int'($urandom_range(8388608, 0)) - 4194304;
            w2 = int'($urandom_range(8388608, 0)) - 4194304;
            rr = int'($urandom_range(335544, 0)) - 167772;
            k  = int'($urandom_range(50331648, 1677722));
            th = int'($urandom_range(33554432, 1677722));
            sg = int'($urandom_range(33554432, 1677722));
            @(negedge clk);
            set_inputs(s, v, w1, w2, t, rr, k, th, sg);
            es = m_s(s, v, rr, t, w1);
            ev = m_v(v, k, th, sg, t, w2);
            pulse_en();
            vectors++;
            if (absdiff(S_out, es) > 200 || absdiff(v_out, ev) > 200) begin
                miscompares++;
                $display("FAIL random_%0d: S_out=%h v_out=%h expected %h %h",
                         i, S_out, v_out, es, ev);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int es, ev;
        es = m_s(32'h02000000, 32'h00400000, 0, 167772, 1677722);
        ev = m_v(32'h00400000, 32'h01000000, 32'h00400000, 32'h00800000, 167772, 1677722);
        @(negedge clk);
        set_inputs(32'h02000000, 32'h00400000, 1677722, 1677722, 167772, 0,
                   32'h01000000, 32'h00400000, 32'h00800000);
        en = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (S_out !== es || v_out !== ev) begin
            miscompares++;
            $display("FAIL b2b_first: S_out=%h v_out=%h expected %h %h", S_out, v_out, es, ev);
        end
        es = m_s(32'h03000000, 32'h00100000, 0, 167772, -1677722);
        ev = m_v(32'h00100000, 32'h01000000, 32'h00400000, 32'h00800000, 167772, -1677722);
        @(negedge clk);
        set_inputs(32'h03000000, 32'h00100000, -1677722, -1677722, 167772, 0,
                   32'h01000000, 32'h00400000, 32'h00800000);
        @(posedge clk); #1;
        en = 1'b0;
        vectors++;
        if (S_out !== es || v_out !== ev) begin
            miscompares++;
            $display("FAIL b2b_second: S_out=%h v_out=%h expected %h %h", S_out, v_out, es, ev);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sq_a = 32'd0;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_nominal();
        test_hold();
        test_sqrt();
        test_zero_variance();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sde_solver_q824.md
Name: sde_solver_q824

Overview:
- One Euler–Maruyama step of the Heston SDE pair in signed Q8.24 fixed point:
  - dS = r·S·dt + sqrt(v)·S·dW1
  - dv = kappa·(theta − v)·dt + sigma·sqrt(v)·dW2
- Sits inside the path-simulation loop of the Heston option pricer: takes the current state (S, v), the two Brownian increments and the model constants; registers the next state.
- Contains a purely combinational Q8.24 square-root sub-block, sqrt_q824, which is also usable standalone.

Parameters:
- none (format fixed: 32-bit signed, 24 fractional bits, 1.0 = 0x01000000)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  step strobe; a state update is computed and registered on an edge where en=1
- S_in  in  32 signed  current asset price, Q8.24
- v_in  in  32 signed  current variance, Q8.24
- dW1  in  32 signed  Brownian increment for S, Q8.24
- dW2  in  32 signed  Brownian increment for v, Q8.24
- dt  in  32 signed  time step, Q8.24
- r  in  32 signed  risk-free rate, Q8.24
- kappa  in  32 signed  mean-reversion speed, Q8.24
- theta  in  32 signed  long-run variance, Q8.24
- sigma  in  32 signed  vol-of-vol, Q8.24
- S_out  out  32 signed  registered next price, Q8.24
- v_out  out  32 signed  registered next variance, Q8.24

Behaviour:
- Reset: on a rising edge with rst=1, S_out=0 and v_out=0. rst has priority over en.
- en=1 (rst=0): S_out and v_out load the results computed from the inputs present at that edge. Latency is one edge: outputs are valid after the edge that samples en and stay valid until the next update.
- en=0 (rst=0): outputs hold.
- Multiply rule (qmul): form the full 64-bit signed product and take bits [55:24]. This is an arithmetic shift right by 24 (floor toward −inf), then wrap to 32 bits. No rounding, no saturation.
- sqrt_q824 (combinational, zero cycles):
  - sqrt_out = floor(sqrt(a·2^24)) for a > 0, so the result is Q8.24.
  - sqrt_out = 0 for a ≤ 0.
  - Use an unrolled digit-by-digit integer square root on the 56-bit radicand a<<24; the result fits in 28 bits.
- The datapath uses sq = sqrt_q824(v_in). Evaluation order is fixed; each qmul truncates separately:
  - S path:
    - a1 = qmul(qmul(r, S_in), dt)
    - b1 = qmul(qmul(sq, S_in), dW1)
    - dS = a1 + b1
    - S_out = S_in + dS (32-bit wrap)
  - v path:
    - vd = theta − v_in
    - a2 = qmul(qmul(kappa, vd), dt)
    - b2 = qmul(qmul(sigma, sq), dW2)
    - dv = a2 + b2
    - v_out = v_in + dv (32-bit wrap)
- No clamping of v_out to ≥ 0; a negative v at a later step is handled by sqrt returning 0.
- The whole computation is combinational between the input ports and the output registers; no internal pipeline.
- Accuracy: results must match the bit-exact model above within ±200 LSB. An exact implementation gives 0 error.

Test Plan:
- Reset: rst=1 for 3 cycles with en=0 -> S_out=0, v_out=0. Assert rst together with en=1 -> outputs still 0.
- Nominal step: S=100.0, v=0.04, r=0.05, dt=0.01, dW1=0.1, kappa=2.0, theta=0.09, sigma=0.3, dW2=−0.1, one en pulse -> S_out≈102.05 (0x66 0CCCCD region, ±200 LSB) and v_out≈0.035 (≈587203 LSB, ±200).
- Hold: after the nominal step, change all inputs with en=0 for 5 cycles -> S_out and v_out unchanged.
- sqrt unit:
  - a=4.0 -> 0x02000000
  - a=2.0 -> 23726566
  - a=1.0 -> 0x01000000
  - a=0 -> 0
  - a=−1.0 -> 0
- Zero variance: v_in=0, theta=0.5, kappa=1.0, dt=0.01, r=0, any dW1/dW2 -> S_out=S_in exactly; v_out≈0.005 (dv = kappa·theta·dt, diffusion terms 0).
- Randomized: 10 steps with S∈[1,101], v∈[0.1,10.1], dt∈[0.002,0.01], dW1/dW2∈[−0.25,0.25], r∈[−0.01,0.01], kappa∈[0.1,3.0], theta/sigma∈[0.1,2.0], each step one en pulse then one idle cycle -> both outputs within ±200 LSB of the bit-exact model.
